// File: rtl/decode_stage.sv
// RV32I decode stage: turns the fetched instruction into registered control
// fields, immediates and operands one cycle later, with no stall path.
module decode_stage (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   inst,
  input  logic [31:0]   reg_pc,
  input  logic [1023:0] regfile,
  output logic [31:0]   imm_i_sext,
  output logic [31:0]   imm_s_sext,
  output logic [31:0]   imm_b_sext,
  output logic [31:0]   imm_j_sext,
  output logic [31:0]   imm_u_shifted,
  output logic [31:0]   imm_z_uext,
  output logic [31:0]   output_reg_pc,
  output logic [4:0]    exe_fun,
  output logic [31:0]   op1_data,
  output logic [31:0]   op2_data,
  output logic [31:0]   rs2_data,
  output logic [4:0]    mem_wen,
  output logic          rf_wen,
  output logic [3:0]    wb_sel,
  output logic [4:0]    wb_addr,
  output logic [2:0]    csr_cmd,
  output logic          jmp_flg
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [4:0] EXE_NONE  = 5'd0;
  localparam logic [4:0] EXE_ADD   = 5'd1;
  localparam logic [4:0] EXE_SUB   = 5'd2;
  localparam logic [4:0] EXE_AND   = 5'd3;
  localparam logic [4:0] EXE_OR    = 5'd4;
  localparam logic [4:0] EXE_XOR   = 5'd5;
  localparam logic [4:0] EXE_SLL   = 5'd6;
  localparam logic [4:0] EXE_SRL   = 5'd7;
  localparam logic [4:0] EXE_SRA   = 5'd8;
  localparam logic [4:0] EXE_SLT   = 5'd9;
  localparam logic [4:0] EXE_SLTU  = 5'd10;
  localparam logic [4:0] EXE_BEQ   = 5'd11;
  localparam logic [4:0] EXE_BNE   = 5'd12;
  localparam logic [4:0] EXE_BLT   = 5'd13;
  localparam logic [4:0] EXE_BGE   = 5'd14;
  localparam logic [4:0] EXE_BLTU  = 5'd15;
  localparam logic [4:0] EXE_BGEU  = 5'd16;
  localparam logic [4:0] EXE_JALR  = 5'd17;
  localparam logic [4:0] EXE_COPY1 = 5'd18;

  localparam logic [4:0] MEN_NONE = 5'd0;
  localparam logic [4:0] MEN_SW   = 5'd1;
  localparam logic [4:0] MEN_SH   = 5'd2;
  localparam logic [4:0] MEN_SB   = 5'd3;

  localparam logic [3:0] WB_NONE = 4'd0;
  localparam logic [3:0] WB_ALU  = 4'd1;
  localparam logic [3:0] WB_LW   = 4'd2;
  localparam logic [3:0] WB_PC4  = 4'd3;
  localparam logic [3:0] WB_CSR  = 4'd4;
  localparam logic [3:0] WB_LB   = 4'd5;
  localparam logic [3:0] WB_LBU  = 4'd6;
  localparam logic [3:0] WB_LH   = 4'd7;
  localparam logic [3:0] WB_LHU  = 4'd8;

  localparam logic [2:0] CSR_NONE  = 3'd0;
  localparam logic [2:0] CSR_ECALL = 3'd4;

  typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO, OP1_ZIMM} op1_sel_e;
  typedef enum logic [2:0] {OP2_RS2, OP2_IMI, OP2_IMS, OP2_IMJ, OP2_IMU} op2_sel_e;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rf_word [32];
  logic [31:0] rs1_data;
  logic [31:0] rs2_data_next;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign funct7   = inst[31:25];
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rf_unpack
      assign rf_word[gi] = regfile[32*gi +: 32];
    end
  endgenerate

  // x0 is hardwired to zero whatever the register file happens to hold there
  assign rs1_data      = (rs1_addr == 5'd0) ? 32'h0 : rf_word[rs1_addr];
  assign rs2_data_next = (rs2_addr == 5'd0) ? 32'h0 : rf_word[rs2_addr];

  logic [31:0] imm_i_next;
  logic [31:0] imm_s_next;
  logic [31:0] imm_b_next;
  logic [31:0] imm_j_next;
  logic [31:0] imm_u_next;
  logic [31:0] imm_z_next;

  assign imm_i_next = {{20{inst[31]}}, inst[31:20]};
  assign imm_s_next = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b_next = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j_next = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u_next = {inst[31:12], 12'h000};
  assign imm_z_next = {27'h0, inst[19:15]};

  op1_sel_e    op1_sel;
  op2_sel_e    op2_sel;
  logic [4:0]  exe_fun_next;
  logic [4:0]  mem_wen_next;
  logic        rf_wen_next;
  logic [3:0]  wb_sel_next;
  logic [2:0]  csr_cmd_next;
  logic        jmp_flg_next;

  always_comb begin
    op1_sel      = OP1_RS1;
    op2_sel      = OP2_RS2;
    exe_fun_next = EXE_NONE;
    mem_wen_next = MEN_NONE;
    rf_wen_next  = 1'b0;
    wb_sel_next  = WB_NONE;
    csr_cmd_next = CSR_NONE;
    jmp_flg_next = 1'b0;

    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'd0:    exe_fun_next = EXE_ADD;
            3'd1:    exe_fun_next = EXE_SLL;
            3'd2:    exe_fun_next = EXE_SLT;
            3'd3:    exe_fun_next = EXE_SLTU;
            3'd4:    exe_fun_next = EXE_XOR;
            3'd5:    exe_fun_next = EXE_SRL;
            3'd6:    exe_fun_next = EXE_OR;
            default: exe_fun_next = EXE_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
          exe_fun_next = EXE_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'd5) begin
          exe_fun_next = EXE_SRA;
        end
        if (exe_fun_next != EXE_NONE) begin
          rf_wen_next = 1'b1;
          wb_sel_next = WB_ALU;
        end
      end

      OPC_OP_IMM: begin
        op2_sel = OP2_IMI;
        case (funct3)
          3'd0: exe_fun_next = EXE_ADD;
          3'd2: exe_fun_next = EXE_SLT;
          3'd3: exe_fun_next = EXE_SLTU;
          3'd4: exe_fun_next = EXE_XOR;
          3'd6: exe_fun_next = EXE_OR;
          3'd7: exe_fun_next = EXE_AND;
          3'd1: if (funct7 == 7'b0000000) exe_fun_next = EXE_SLL;
          default: begin
            // funct3 = 5: shift-right, arithmetic when inst[30] is set
            if (funct7 == 7'b0000000)      exe_fun_next = EXE_SRL;
            else if (funct7 == 7'b0100000) exe_fun_next = EXE_SRA;
          end
        endcase
        if (exe_fun_next != EXE_NONE) begin
          rf_wen_next = 1'b1;
          wb_sel_next = WB_ALU;
        end
      end

      OPC_LOAD: begin
        op2_sel = OP2_IMI;
        case (funct3)
          3'd0:    wb_sel_next = WB_LB;
          3'd1:    wb_sel_next = WB_LH;
          3'd2:    wb_sel_next = WB_LW;
          3'd4:    wb_sel_next = WB_LBU;
          3'd5:    wb_sel_next = WB_LHU;
          default: wb_sel_next = WB_NONE;
        endcase
        if (wb_sel_next != WB_NONE) begin
          exe_fun_next = EXE_ADD;
          rf_wen_next  = 1'b1;
        end
      end

      OPC_STORE: begin
        op2_sel = OP2_IMS;
        case (funct3)
          3'd0:    mem_wen_next = MEN_SB;
          3'd1:    mem_wen_next = MEN_SH;
          3'd2:    mem_wen_next = MEN_SW;
          default: mem_wen_next = MEN_NONE;
        endcase
        if (mem_wen_next != MEN_NONE) exe_fun_next = EXE_ADD;
      end

      OPC_BRANCH: begin
        case (funct3)
          3'd0:    exe_fun_next = EXE_BEQ;
          3'd1:    exe_fun_next = EXE_BNE;
          3'd4:    exe_fun_next = EXE_BLT;
          3'd5:    exe_fun_next = EXE_BGE;
          3'd6:    exe_fun_next = EXE_BLTU;
          3'd7:    exe_fun_next = EXE_BGEU;
          default: exe_fun_next = EXE_NONE;
        endcase
      end

      OPC_JAL: begin
        op1_sel      = OP1_PC;
        op2_sel      = OP2_IMJ;
        exe_fun_next = EXE_ADD;
        rf_wen_next  = 1'b1;
        wb_sel_next  = WB_PC4;
        jmp_flg_next = 1'b1;
      end

      OPC_JALR: begin
        op2_sel = OP2_IMI;
        if (funct3 == 3'd0) begin
          exe_fun_next = EXE_JALR;
          rf_wen_next  = 1'b1;
          wb_sel_next  = WB_PC4;
          jmp_flg_next = 1'b1;
        end
      end

      OPC_LUI, OPC_AUIPC: begin
        op1_sel      = (opcode == OPC_LUI) ? OP1_ZERO : OP1_PC;
        op2_sel      = OP2_IMU;
        exe_fun_next = EXE_ADD;
        rf_wen_next  = 1'b1;
        wb_sel_next  = WB_ALU;
      end

      OPC_SYSTEM: begin
        if (inst == 32'h0000_0073) begin
          csr_cmd_next = CSR_ECALL;
        end else if (funct3[1:0] != 2'b00) begin
          // funct3[1:0] is W/S/C directly; funct3[2] selects the zimm form
          op1_sel      = funct3[2] ? OP1_ZIMM : OP1_RS1;
          op2_sel      = OP2_IMI;
          exe_fun_next = EXE_COPY1;
          csr_cmd_next = {1'b0, funct3[1:0]};
          rf_wen_next  = 1'b1;
          wb_sel_next  = WB_CSR;
        end
      end

      default: begin
        exe_fun_next = EXE_NONE;
      end
    endcase
  end

  logic [31:0] op1_next;
  logic [31:0] op2_next;

  always_comb begin
    op1_next = rs1_data;
    case (op1_sel)
      OP1_PC:   op1_next = reg_pc;
      OP1_ZERO: op1_next = 32'h0;
      OP1_ZIMM: op1_next = imm_z_next;
      default:  op1_next = rs1_data;
    endcase
  end

  always_comb begin
    op2_next = rs2_data_next;
    case (op2_sel)
      OP2_IMI: op2_next = imm_i_next;
      OP2_IMS: op2_next = imm_s_next;
      OP2_IMJ: op2_next = imm_j_next;
      OP2_IMU: op2_next = imm_u_next;
      default: op2_next = rs2_data_next;
    endcase
  end

  logic [31:0] imm_i_reg, imm_s_reg, imm_b_reg, imm_j_reg, imm_u_reg, imm_z_reg;
  logic [31:0] pc_reg, op1_reg, op2_reg, rs2_data_reg;
  logic [4:0]  exe_fun_reg, mem_wen_reg, wb_addr_reg;
  logic        rf_wen_reg, jmp_flg_reg;
  logic [3:0]  wb_sel_reg;
  logic [2:0]  csr_cmd_reg;

  // Reset forces a full bubble, data fields included
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imm_i_reg    <= '0;
      imm_s_reg    <= '0;
      imm_b_reg    <= '0;
      imm_j_reg    <= '0;
      imm_u_reg    <= '0;
      imm_z_reg    <= '0;
      pc_reg       <= '0;
      op1_reg      <= '0;
      op2_reg      <= '0;
      rs2_data_reg <= '0;
      exe_fun_reg  <= '0;
      mem_wen_reg  <= '0;
      wb_addr_reg  <= '0;
      rf_wen_reg   <= 1'b0;
      jmp_flg_reg  <= 1'b0;
      wb_sel_reg   <= '0;
      csr_cmd_reg  <= '0;
    end else begin
      imm_i_reg    <= imm_i_next;
      imm_s_reg    <= imm_s_next;
      imm_b_reg    <= imm_b_next;
      imm_j_reg    <= imm_j_next;
      imm_u_reg    <= imm_u_next;
      imm_z_reg    <= imm_z_next;
      pc_reg       <= reg_pc;
      op1_reg      <= op1_next;
      op2_reg      <= op2_next;
      rs2_data_reg <= rs2_data_next;
      exe_fun_reg  <= exe_fun_next;
      mem_wen_reg  <= mem_wen_next;
      wb_addr_reg  <= inst[11:7];
      rf_wen_reg   <= rf_wen_next;
      jmp_flg_reg  <= jmp_flg_next;
      wb_sel_reg   <= wb_sel_next;
      csr_cmd_reg  <= csr_cmd_next;
    end
  end

  assign imm_i_sext    = imm_i_reg;
  assign imm_s_sext    = imm_s_reg;
  assign imm_b_sext    = imm_b_reg;
  assign imm_j_sext    = imm_j_reg;
  assign imm_u_shifted = imm_u_reg;
  assign imm_z_uext    = imm_z_reg;
  assign output_reg_pc = pc_reg;
  assign op1_data      = op1_reg;
  assign op2_data      = op2_reg;
  assign rs2_data      = rs2_data_reg;
  assign exe_fun       = exe_fun_reg;
  assign mem_wen       = mem_wen_reg;
  assign wb_addr       = wb_addr_reg;
  assign rf_wen        = rf_wen_reg;
  assign jmp_flg       = jmp_flg_reg;
  assign wb_sel        = wb_sel_reg;
  assign csr_cmd       = csr_cmd_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: an opcode-table model (mask/match per mnemonic)
// predicts every registered output, plus literal checks on known encodings.
module tb_decode_stage;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   inst;
  logic [31:0]   reg_pc;
  logic [1023:0] regfile;
  logic [31:0]   imm_i_sext, imm_s_sext, imm_b_sext, imm_j_sext, imm_u_shifted, imm_z_uext;
  logic [31:0]   output_reg_pc, op1_data, op2_data, rs2_data;
  logic [4:0]    exe_fun, mem_wen, wb_addr;
  logic          rf_wen, jmp_flg;
  logic [3:0]    wb_sel;
  logic [2:0]    csr_cmd;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .reg_pc(reg_pc), .regfile(regfile),
    .imm_i_sext(imm_i_sext), .imm_s_sext(imm_s_sext), .imm_b_sext(imm_b_sext),
    .imm_j_sext(imm_j_sext), .imm_u_shifted(imm_u_shifted), .imm_z_uext(imm_z_uext),
    .output_reg_pc(output_reg_pc), .exe_fun(exe_fun), .op1_data(op1_data),
    .op2_data(op2_data), .rs2_data(rs2_data), .mem_wen(mem_wen), .rf_wen(rf_wen),
    .wb_sel(wb_sel), .wb_addr(wb_addr), .csr_cmd(csr_cmd), .jmp_flg(jmp_flg)
  );

  // operand source codes used by the opcode table
  localparam int NA = 0, RS = 1, PC = 2, ZR = 3, ZI = 4;
  localparam int IMI = 2, IMS = 3, IMJ = 4, IMU = 5;

  typedef struct {
    logic [31:0] mask, match;
    int exe, o1, o2, mem, rf, wb, csr, jmp;
  } pat_t;

  typedef struct {
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_z, pc, op1, op2, rs2d;
    logic [4:0]  exe, mem, wba;
    logic        rf, jmp;
    logic [3:0]  wb;
    logic [2:0]  csr;
    bit          op_care;
  } exp_t;

  pat_t pats[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;
  exp_t cur_e;

  function automatic void add_pat(input logic [31:0] mask, input logic [31:0] match,
                                  input int exe, input int o1, input int o2, input int mem,
                                  input int rf, input int wb, input int csr, input int jmp);
    pat_t p;
    p.mask = mask; p.match = match; p.exe = exe; p.o1 = o1; p.o2 = o2;
    p.mem = mem; p.rf = rf; p.wb = wb; p.csr = csr; p.jmp = jmp;
    pats.push_back(p);
  endfunction

  function automatic void build_table();
    logic [31:0] mr, mi, mo;
    mr = 32'hFE00707F; mi = 32'h0000707F; mo = 32'h0000007F;
    add_pat(mr, 32'h00000033, 1, RS, RS, 0, 1, 1, 0, 0);   // ADD
    add_pat(mr, 32'h40000033, 2, RS, RS, 0, 1, 1, 0, 0);   // SUB
    add_pat(mr, 32'h00001033, 6, RS, RS, 0, 1, 1, 0, 0);   // SLL
    add_pat(mr, 32'h00002033, 9, RS, RS, 0, 1, 1, 0, 0);   // SLT
    add_pat(mr, 32'h00003033, 10, RS, RS, 0, 1, 1, 0, 0);  // SLTU
    add_pat(mr, 32'h00004033, 5, RS, RS, 0, 1, 1, 0, 0);   // XOR
    add_pat(mr, 32'h00005033, 7, RS, RS, 0, 1, 1, 0, 0);   // SRL
    add_pat(mr, 32'h40005033, 8, RS, RS, 0, 1, 1, 0, 0);   // SRA
    add_pat(mr, 32'h00006033, 4, RS, RS, 0, 1, 1, 0, 0);   // OR
    add_pat(mr, 32'h00007033, 3, RS, RS, 0, 1, 1, 0, 0);   // AND
    add_pat(mi, 32'h00000013, 1, RS, IMI, 0, 1, 1, 0, 0);  // ADDI
    add_pat(mi, 32'h00002013, 9, RS, IMI, 0, 1, 1, 0, 0);  // SLTI
    add_pat(mi, 32'h00003013, 10, RS, IMI, 0, 1, 1, 0, 0); // SLTIU
    add_pat(mi, 32'h00004013, 5, RS, IMI, 0, 1, 1, 0, 0);  // XORI
    add_pat(mi, 32'h00006013, 4, RS, IMI, 0, 1, 1, 0, 0);  // ORI
    add_pat(mi, 32'h00007013, 3, RS, IMI, 0, 1, 1, 0, 0);  // ANDI
    add_pat(mr, 32'h00001013, 6, RS, IMI, 0, 1, 1, 0, 0);  // SLLI
    add_pat(mr, 32'h00005013, 7, RS, IMI, 0, 1, 1, 0, 0);  // SRLI
    add_pat(mr, 32'h40005013, 8, RS, IMI, 0, 1, 1, 0, 0);  // SRAI
    add_pat(mi, 32'h00000003, 1, RS, IMI, 0, 1, 5, 0, 0);  // LB
    add_pat(mi, 32'h00001003, 1, RS, IMI, 0, 1, 7, 0, 0);  // LH
    add_pat(mi, 32'h00002003, 1, RS, IMI, 0, 1, 2, 0, 0);  // LW
    add_pat(mi, 32'h00004003, 1, RS, IMI, 0, 1, 6, 0, 0);  // LBU
    add_pat(mi, 32'h00005003, 1, RS, IMI, 0, 1, 8, 0, 0);  // LHU
    add_pat(mi, 32'h00000023, 1, RS, IMS, 3, 0, 0, 0, 0);  // SB
    add_pat(mi, 32'h00001023, 1, RS, IMS, 2, 0, 0, 0, 0);  // SH
    add_pat(mi, 32'h00002023, 1, RS, IMS, 1, 0, 0, 0, 0);  // SW
    add_pat(mi, 32'h00000063, 11, RS, RS, 0, 0, 0, 0, 0);  // BEQ
    add_pat(mi, 32'h00001063, 12, RS, RS, 0, 0, 0, 0, 0);  // BNE
    add_pat(mi, 32'h00004063, 13, RS, RS, 0, 0, 0, 0, 0);  // BLT
    add_pat(mi, 32'h00005063, 14, RS, RS, 0, 0, 0, 0, 0);  // BGE
    add_pat(mi, 32'h00006063, 15, RS, RS, 0, 0, 0, 0, 0);  // BLTU
    add_pat(mi, 32'h00007063, 16, RS, RS, 0, 0, 0, 0, 0);  // BGEU
    add_pat(mo, 32'h0000006F, 1, PC, IMJ, 0, 1, 3, 0, 1);  // JAL
    add_pat(mi, 32'h00000067, 17, RS, IMI, 0, 1, 3, 0, 1); // JALR
    add_pat(mo, 32'h00000037, 1, ZR, IMU, 0, 1, 1, 0, 0);  // LUI
    add_pat(mo, 32'h00000017, 1, PC, IMU, 0, 1, 1, 0, 0);  // AUIPC
    add_pat(mi, 32'h00001073, 18, RS, IMI, 0, 1, 4, 1, 0); // CSRRW
    add_pat(mi, 32'h00002073, 18, RS, IMI, 0, 1, 4, 2, 0); // CSRRS
    add_pat(mi, 32'h00003073, 18, RS, IMI, 0, 1, 4, 3, 0); // CSRRC
    add_pat(mi, 32'h00005073, 18, ZI, IMI, 0, 1, 4, 1, 0); // CSRRWI
    add_pat(mi, 32'h00006073, 18, ZI, IMI, 0, 1, 4, 2, 0); // CSRRSI
    add_pat(mi, 32'h00007073, 18, ZI, IMI, 0, 1, 4, 3, 0); // CSRRCI
    add_pat(32'hFFFFFFFF, 32'h00000073, 0, NA, NA, 0, 0, 0, 4, 0); // ECALL
  endfunction

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc,
                                 input logic [1023:0] rf);
    exp_t e;
    int r1, r2;
    logic [31:0] v1, v2, sx;
    bit found;
    r1 = int'((i >> 15) & 32'h1F);
    r2 = int'((i >> 20) & 32'h1F);
    v1 = (r1 == 0) ? 32'h0 : rf[32*r1 +: 32];
    v2 = (r2 == 0) ? 32'h0 : rf[32*r2 +: 32];
    sx = (i[31] == 1'b1) ? 32'hFFFFFFFF : 32'h0;
    e.imm_i = (sx << 12) | (i >> 20);
    e.imm_s = (sx << 12) | ((i >> 20) & 32'hFE0) | ((i >> 7) & 32'h1F);
    e.imm_b = (sx << 12) | (((i >> 7) & 32'h1) << 11) | (((i >> 25) & 32'h3F) << 5)
            | (((i >> 8) & 32'hF) << 1);
    e.imm_j = (sx << 20) | (i & 32'h000FF000) | (((i >> 20) & 32'h1) << 11)
            | (((i >> 21) & 32'h3FF) << 1);
    e.imm_u = i & 32'hFFFFF000;
    e.imm_z = (i >> 15) & 32'h1F;
    e.pc = pc;
    e.rs2d = v2;
    e.wba = 5'((i >> 7) & 32'h1F);
    e.exe = 0; e.mem = 0; e.rf = 0; e.jmp = 0; e.wb = 0; e.csr = 0;
    e.op1 = 0; e.op2 = 0; e.op_care = 1'b0;
    found = 1'b0;
    for (int k = 0; k < pats.size(); k++) begin
      if (!found && ((i & pats[k].mask) == pats[k].match)) begin
        found = 1'b1;
        e.exe = 5'(pats[k].exe); e.mem = 5'(pats[k].mem); e.rf = 1'(pats[k].rf);
        e.wb = 4'(pats[k].wb); e.csr = 3'(pats[k].csr); e.jmp = 1'(pats[k].jmp);
        e.op_care = (pats[k].o1 != NA);
        case (pats[k].o1)
          PC:      e.op1 = pc;
          ZR:      e.op1 = 32'h0;
          ZI:      e.op1 = e.imm_z;
          default: e.op1 = v1;
        endcase
        case (pats[k].o2)
          IMI:     e.op2 = e.imm_i;
          IMS:     e.op2 = e.imm_s;
          IMJ:     e.op2 = e.imm_j;
          IMU:     e.op2 = e.imm_u;
          default: e.op2 = v2;
        endcase
      end
    end
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.imm_i = 0; e.imm_s = 0; e.imm_b = 0; e.imm_j = 0; e.imm_u = 0; e.imm_z = 0;
    e.pc = 0; e.op1 = 0; e.op2 = 0; e.rs2d = 0; e.exe = 0; e.mem = 0; e.wba = 0;
    e.rf = 0; e.jmp = 0; e.wb = 0; e.csr = 0; e.op_care = 1'b1;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s inst=%08h: got %08h, expected %08h", name, inst, act, req);
    end
  endtask

  task automatic compare_all(input exp_t e);
    chk("imm_i", imm_i_sext, e.imm_i);
    chk("imm_s", imm_s_sext, e.imm_s);
    chk("imm_b", imm_b_sext, e.imm_b);
    chk("imm_j", imm_j_sext, e.imm_j);
    chk("imm_u", imm_u_shifted, e.imm_u);
    chk("imm_z", imm_z_uext, e.imm_z);
    chk("pc", output_reg_pc, e.pc);
    chk("rs2_data", rs2_data, e.rs2d);
    chk("exe_fun", 32'(exe_fun), 32'(e.exe));
    chk("mem_wen", 32'(mem_wen), 32'(e.mem));
    chk("rf_wen", 32'(rf_wen), 32'(e.rf));
    chk("wb_sel", 32'(wb_sel), 32'(e.wb));
    chk("wb_addr", 32'(wb_addr), 32'(e.wba));
    chk("csr_cmd", 32'(csr_cmd), 32'(e.csr));
    chk("jmp_flg", 32'(jmp_flg), 32'(e.jmp));
    if (e.op_care) begin
      chk("op1", op1_data, e.op1);
      chk("op2", op2_data, e.op2);
    end
  endtask

  // Predict from the inputs seen at the edge, check just after it
  always @(posedge clk) begin
    cur_e = rst_n ? model(inst, reg_pc, regfile) : reset_exp();
    #1;
    if (chk_en) begin
      compare_all(cur_e);
      $display("cycle inst=%08h pc=%08h exe=%0d op1=%08h op2=%08h wb=%0d",
               inst, output_reg_pc, exe_fun, op1_data, op2_data, wb_sel);
    end
  end

  task automatic drive(input logic [31:0] i, input logic [31:0] pc);
    @(negedge clk);
    inst = i;
    reg_pc = pc;
    @(posedge clk);
    #2;
  endtask

  logic [31:0] vecs[$] = '{
    32'h002081B3, 32'h40208233, 32'h4020D2B3, 32'h4030D313, 32'h0030D313,
    32'hFFF13393, 32'hFFC08403, 32'h0040D483, 32'h00209463, 32'h0020F463,
    32'h0020A063, 32'h000280E7, 32'h00001517, 32'h300095F3, 32'h3002E673,
    32'h3000B6F3, 32'h00000073, 32'h0000000F, 32'h022081B3, 32'h00100073,
    32'h00008033, 32'h0020C1B3
  };

  initial begin
    exp_t m;
    rst_n = 1'b0;
    inst = 32'h00500093;
    reg_pc = 32'h0;
    for (int k = 0; k < 32; k++) regfile[32*k +: 32] = 32'h0A000000 + 32'(k * 32'h111);
    regfile[31:0]  = 32'hFFFFFFFF;
    regfile[63:32] = 32'h00000100;
    regfile[95:64] = 32'hDEADBEEF;
    regfile[191:160] = 32'h80000004;
    build_table();

    // model pins against hand-worked encodings
    m = model(32'h010000EF, 32'h40, regfile);
    chk("model_jal_imm_j", m.imm_j, 32'd16);
    m = model(32'h0020A423, 32'h0, regfile);
    chk("model_sw_op1", m.op1, 32'h100);
    chk("model_sw_op2", m.op2, 32'd8);

    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_exe_fun", 32'(exe_fun), 32'd0);
    chk("reset_op2", op2_data, 32'd0);
    rst_n = 1'b1;

    drive(32'h00500093, 32'h10);
    chk("addi_exe", 32'(exe_fun), 32'd1);
    chk("addi_op1_x0", op1_data, 32'd0);
    chk("addi_op2", op2_data, 32'd5);
    chk("addi_rf_wen", 32'(rf_wen), 32'd1);
    chk("addi_wb_sel", 32'(wb_sel), 32'd1);
    chk("addi_wb_addr", 32'(wb_addr), 32'd1);
    chk("addi_pc", output_reg_pc, 32'h10);

    drive(32'h0020A423, 32'h14);
    chk("sw_op1", op1_data, 32'h100);
    chk("sw_op2", op2_data, 32'd8);
    chk("sw_rs2", rs2_data, 32'hDEADBEEF);
    chk("sw_mem_wen", 32'(mem_wen), 32'd1);
    chk("sw_rf_wen", 32'(rf_wen), 32'd0);

    drive(32'h010000EF, 32'h40);
    chk("jal_op1", op1_data, 32'h40);
    chk("jal_op2", op2_data, 32'd16);
    chk("jal_imm_j", imm_j_sext, 32'd16);
    chk("jal_wb_sel", 32'(wb_sel), 32'd3);
    chk("jal_jmp", 32'(jmp_flg), 32'd1);
    chk("jal_wb_addr", 32'(wb_addr), 32'd1);

    drive(32'h123452B7, 32'h44);
    chk("lui_op1", op1_data, 32'd0);
    chk("lui_op2", op2_data, 32'h12345000);
    chk("lui_rf_wen", 32'(rf_wen), 32'd1);
    chk("lui_wb_addr", 32'(wb_addr), 32'd5);

    drive(32'hFFFFFFFF, 32'h48);
    chk("bad_exe", 32'(exe_fun), 32'd0);
    chk("bad_rf_wen", 32'(rf_wen), 32'd0);
    chk("bad_imm_i", imm_i_sext, 32'hFFFFFFFF);
    chk("bad_wb_addr", 32'(wb_addr), 32'd31);

    for (int k = 0; k < vecs.size(); k++) drive(vecs[k], 32'h1000 + 32'(k * 4));

    // one-edge reset mid-stream, then the very next edge decodes again
    rst_n = 1'b0;
    drive(32'h00500093, 32'h2000);
    chk("midrst_exe", 32'(exe_fun), 32'd0);
    chk("midrst_pc", output_reg_pc, 32'd0);
    chk("midrst_op2", op2_data, 32'd0);
    rst_n = 1'b1;
    drive(32'h00500093, 32'h2004);
    chk("post_rst_exe", 32'(exe_fun), 32'd1);
    chk("post_rst_pc", output_reg_pc, 32'h2004);

    chk_en = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
